// File: rtl/psum_pkg.sv
// psum_pkg: default sizing and the saturating narrowing helper for the partial-sum assembler
package psum_pkg;
  localparam int MACRO_NUM_DEF = 32;
  localparam int MPG_DEF = 8;
  localparam int MACRO_OUT_DEF = 64;
  localparam int PASS_NUM_DEF = 2;
  localparam int IN_DW_DEF = 5;
  localparam int OUT_DW_DEF = 16;
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] s, input int ow, output logic ov);
    logic signed [31:0] mx;
    mx = (32'sd1 <<< (ow - 1)) - 32'sd1;
    ov = (s > mx) || (s < ~mx);
    return ov ? (s[31] ? ~mx : mx) : s;
  endfunction
endpackage

// File: rtl/psum_group_adder.sv
// psum_group_adder: one group's per-column macro reduction with saturation, registered as stage 1
module psum_group_adder import psum_pkg::*; #(
  parameter int MPG = MPG_DEF,
  parameter int MACRO_OUT = MACRO_OUT_DEF,
  parameter int IN_DW = IN_DW_DEF,
  parameter int OUT_DW = OUT_DW_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [MPG*MACRO_OUT*IN_DW-1:0] data_in,
  output logic [MACRO_OUT*OUT_DW-1:0]    sum,
  output logic                          sat
);
  logic [MACRO_OUT*OUT_DW-1:0] sum_d;
  logic sat_d, ov;
  logic signed [31:0] acc;
  logic signed [IN_DW-1:0] e;
  always_comb begin
    sum_d = '0;
    sat_d = 1'b0;
    ov = 1'b0;
    acc = '0;
    e = '0;
    for (int c = 0; c < MACRO_OUT; c++) begin
      acc = '0;
      for (int k = 0; k < MPG; k++) begin
        e = data_in[(k*MACRO_OUT+c)*IN_DW +: IN_DW];
        acc = acc + 32'(e);
      end
      sum_d[c*OUT_DW +: OUT_DW] = OUT_DW'(sat_add(acc, OUT_DW, ov));
      sat_d = sat_d | ov;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sum <= '0;
      sat <= 1'b0;
    end else if (en) begin
      sum <= sum_d;
      sat <= sat_d;
    end
endmodule

// File: rtl/partial_sum_assembler.sv
// partial_sum_assembler: multi-pass slot assembly of saturated group sums into a full channel vector
module partial_sum_assembler import psum_pkg::*; #(
  parameter int MACRO_NUM = MACRO_NUM_DEF,
  parameter int MACRO_PER_GROUP = MPG_DEF,
  parameter int MACRO_OUT = MACRO_OUT_DEF,
  parameter int PASS_NUM = PASS_NUM_DEF,
  parameter int IN_DW = IN_DW_DEF,
  parameter int OUT_DW = OUT_DW_DEF,
  localparam int GROUP_NUM = MACRO_NUM / MACRO_PER_GROUP,
  localparam int SLOT = GROUP_NUM * MACRO_OUT,
  localparam int CHANNEL_NUM = SLOT * PASS_NUM,
  localparam int PW = $clog2(PASS_NUM) + 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               mode,
  input  logic                               data_e,
  input  logic                               pass_clr,
  input  logic [MACRO_NUM*MACRO_OUT*IN_DW-1:0] data_in,
  output logic [CHANNEL_NUM*OUT_DW-1:0]        data_out,
  output logic                               data_e_out,
  output logic                               sat_out,
  output logic [PW-1:0]                      pass_cnt
);
  localparam int GIN = MACRO_PER_GROUP * MACRO_OUT * IN_DW;
  localparam int GOUT = MACRO_OUT * OUT_DW;
  logic acc, v1, wr, last1, sat1, sticky;
  logic [PW-1:0] p_now, p_nxt, p1;
  logic [SLOT*OUT_DW-1:0] s1;
  logic [GROUP_NUM-1:0] gsat;
  for (genvar g = 0; g < GROUP_NUM; g++) begin : g_grp
    psum_group_adder #(.MPG(MACRO_PER_GROUP), .MACRO_OUT(MACRO_OUT), .IN_DW(IN_DW), .OUT_DW(OUT_DW)) u_add (
      .clk(clk),
      .rst_n(rst_n),
      .en(acc),
      .data_in(data_in[g*GIN +: GIN]),
      .sum(s1[g*GOUT +: GOUT]),
      .sat(gsat[g])
    );
  end
  assign acc = mode & data_e;
  assign p_now = pass_clr ? '0 : pass_cnt;
  assign p_nxt = (p_now == PW'(PASS_NUM - 1)) ? '0 : p_now + PW'(1);
  assign wr = v1 & mode;
  assign last1 = p1 == PW'(PASS_NUM - 1);
  assign sat1 = |gsat;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pass_cnt <= '0;
      v1 <= 1'b0;
      p1 <= '0;
      sticky <= 1'b0;
      data_e_out <= 1'b0;
      sat_out <= 1'b0;
      data_out <= '0;
    end else begin
      pass_cnt <= acc ? p_nxt : (!mode || pass_clr) ? '0 : pass_cnt;
      v1 <= acc;
      if (acc) p1 <= p_now;
      sticky <= (!mode || pass_clr || (wr && last1)) ? 1'b0 : sticky | (wr & sat1);
      data_e_out <= wr & last1;
      sat_out <= wr & last1 & (sticky | sat1);
      for (int p = 0; p < PASS_NUM; p++)
        if (wr && p1 == PW'(p)) data_out[p*SLOT*OUT_DW +: SLOT*OUT_DW] <= s1;
    end
endmodule

// File: tb/tb_partial_sum_assembler.sv
// tb_partial_sum_assembler: table, directed and randomized model-based checks of the assembler
module tb_partial_sum_assembler;
  localparam int AIN = 32*64*5;
  localparam int AOUT = 512*16;
  localparam int BIN = 8*4*5;
  localparam int BOUT = 32*6;
  logic clk = 1'b0;
  logic rst_n;
  logic a_mode, a_de, a_clr, a_deo, a_sat;
  logic [AIN-1:0] a_din;
  logic [AOUT-1:0] a_dout;
  logic [1:0] a_pc;
  logic b_mode, b_de, b_clr, b_deo, b_sat;
  logic [BIN-1:0] b_din;
  logic [BOUT-1:0] b_dout;
  logic [2:0] b_pc;
  always #5 clk = ~clk;
  partial_sum_assembler u_a (
    .clk(clk), .rst_n(rst_n), .mode(a_mode), .data_e(a_de), .pass_clr(a_clr), .data_in(a_din),
    .data_out(a_dout), .data_e_out(a_deo), .sat_out(a_sat), .pass_cnt(a_pc)
  );
  partial_sum_assembler #(.MACRO_NUM(8), .MACRO_PER_GROUP(4), .MACRO_OUT(4), .PASS_NUM(4), .IN_DW(5), .OUT_DW(6)) u_b (
    .clk(clk), .rst_n(rst_n), .mode(b_mode), .data_e(b_de), .pass_clr(b_clr), .data_in(b_din),
    .data_out(b_dout), .data_e_out(b_deo), .sat_out(b_sat), .pass_cnt(b_pc)
  );
  typedef struct {int in0; int in1; int e0; int e1; int pc; bit strobe; bit sat;} vec_t;
  vec_t tbl[8];
  int din[32][64];
  int exp_out[512];
  int pvals[256];
  int pcnt, pp, checks, errors;
  bit pv, psat, fsat;
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic fill_a(input int v);
    for (int m = 0; m < 32; m++) for (int c = 0; c < 64; c++) din[m][c] = v;
  endtask
  task automatic fill_rand;
    for (int m = 0; m < 32; m++) for (int c = 0; c < 64; c++) din[m][c] = int'($urandom_range(0, 31)) - 16;
  endtask
  task automatic model_reset;
    for (int i = 0; i < 512; i++) exp_out[i] = 0;
    pcnt = 0;
    fsat = 0;
    pv = 0;
  endtask
  task automatic cyc_a(input bit m, input bit de, input bit clr);
    bit es, ess;
    int p, s, bad;
    for (int i = 0; i < 32; i++) for (int c = 0; c < 64; c++) a_din[(i*64+c)*5 +: 5] = 5'(din[i][c]);
    a_mode = m;
    a_de = de;
    a_clr = clr;
    tick;
    es = 0;
    ess = 0;
    if (pv && m) begin
      for (int i = 0; i < 256; i++) exp_out[pp*256+i] = pvals[i];
      if (pp == 1) begin
        es = 1;
        ess = fsat | psat;
        fsat = 0;
      end else fsat = fsat | psat;
    end
    pv = 0;
    if (!m || clr) fsat = 0;
    if (m && de) begin
      p = clr ? 0 : pcnt;
      psat = 0;
      for (int g = 0; g < 4; g++) for (int c = 0; c < 64; c++) begin
        s = 0;
        for (int k = 0; k < 8; k++) s += din[g*8+k][c];
        if (s > 32767) begin s = 32767; psat = 1; end
        else if (s < -32768) begin s = -32768; psat = 1; end
        pvals[g*64+c] = s;
      end
      pv = 1;
      pp = p;
      pcnt = (p + 1) % 2;
    end else if (!m || clr) pcnt = 0;
    chk("a_data_e_out", a_deo, es);
    chk("a_sat_out", a_sat, ess);
    chk("a_pass_cnt", a_pc, pcnt);
    bad = 0;
    for (int i = 0; i < 512; i++)
      if (int'($signed(a_dout[i*16 +: 16])) != exp_out[i]) begin
        bad = i;
        break;
      end
    chk($sformatf("a_data_out[%0d]", bad), int'($signed(a_dout[bad*16 +: 16])), exp_out[bad]);
  endtask
  function automatic int a_ch(input int i);
    return int'($signed(a_dout[i*16 +: 16]));
  endfunction
  task automatic chk_b_frame(input int base, input string n);
    int bad, ba, be, act, exp;
    bad = 0; ba = 0; be = 0;
    for (int p = 0; p < 4; p++) for (int g = 0; g < 2; g++) for (int c = 0; c < 4; c++) begin
      exp = (g == 0) ? tbl[base+p].e0 : tbl[base+p].e1;
      act = int'($signed(b_dout[(p*8+g*4+c)*6 +: 6]));
      if (act != exp && bad == 0) begin bad = 1; ba = act; be = exp; end
    end
    if (bad == 0) begin
      ba = int'($signed(b_dout[5:0]));
      be = tbl[base].e0;
    end
    chk(n, ba, be);
  endtask
  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    {a_mode, a_de, a_clr, b_mode, b_de, b_clr} = '0;
    a_din = '0;
    b_din = '0;
    model_reset;
    fill_a(0);
    tbl[0] = '{1, 2, 4, 8, 1, 0, 0};
    tbl[1] = '{-3, 5, -12, 20, 2, 0, 0};
    tbl[2] = '{7, -8, 28, -32, 3, 0, 0};
    tbl[3] = '{15, -16, 31, -32, 0, 0, 0};
    tbl[4] = '{0, 0, 0, 0, 1, 1, 1};
    tbl[5] = '{-1, 6, -4, 24, 2, 0, 0};
    tbl[6] = '{7, -7, 28, -28, 3, 0, 0};
    tbl[7] = '{-4, 3, -16, 12, 0, 0, 0};
    repeat (2) @(negedge clk);
    chk("rst_a_pass_cnt", a_pc, 0);
    chk("rst_a_data_e_out", a_deo, 0);
    chk("rst_a_sat_out", a_sat, 0);
    chk("rst_a_data_out_nonzero", int'(a_dout != '0), 0);
    chk("rst_b_data_out_nonzero", int'(b_dout != '0), 0);
    chk("rst_b_pass_cnt", b_pc, 0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      for (int m = 0; m < 8; m++) for (int c = 0; c < 4; c++)
        b_din[(m*4+c)*5 +: 5] = 5'(m < 4 ? tbl[i].in0 : tbl[i].in1);
      b_mode = 1;
      b_de = 1;
      tick;
      chk($sformatf("b_pass_cnt[%0d]", i), b_pc, tbl[i].pc);
      chk($sformatf("b_data_e_out[%0d]", i), b_deo, tbl[i].strobe);
      chk($sformatf("b_sat_out[%0d]", i), b_sat, tbl[i].sat);
      if (i == 4) chk_b_frame(0, "b_frame1");
    end
    b_de = 0;
    tick;
    chk("b_data_e_out_frame2", b_deo, 1);
    chk("b_sat_out_frame2", b_sat, 0);
    chk_b_frame(4, "b_frame2");
    tick;
    chk("b_data_e_out_one_cycle", b_deo, 0);
    fill_a(1);
    cyc_a(1, 1, 0);
    cyc_a(1, 0, 0);
    chk("t1_slot0", a_ch(0), 8);
    chk("t1_slot1_untouched", a_ch(256), 0);
    cyc_a(1, 1, 0);
    cyc_a(1, 0, 0);
    chk("t1_slot1", a_ch(511), 8);
    chk("t1_strobe", a_deo, 1);
    cyc_a(1, 0, 0);
    fill_a(2);
    cyc_a(1, 1, 0);
    fill_a(3);
    cyc_a(1, 1, 1);
    cyc_a(1, 0, 0);
    chk("t4_clr_slot0", a_ch(0), 24);
    chk("t4_no_strobe", a_deo, 0);
    fill_a(-1);
    cyc_a(1, 1, 0);
    cyc_a(1, 0, 0);
    chk("t4_complete", a_deo, 1);
    chk("t4_slot1", a_ch(300), -8);
    fill_a(4);
    cyc_a(1, 1, 0);
    fill_a(5);
    cyc_a(1, 1, 0);
    cyc_a(0, 0, 0);
    chk("t5_no_strobe", a_deo, 0);
    chk("t5_slot1_held", a_ch(256), -8);
    fill_a(6);
    cyc_a(1, 1, 0);
    cyc_a(1, 0, 0);
    chk("t5_slot0", a_ch(0), 48);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_data_out_nonzero", int'(a_dout != '0), 0);
    chk("t6_pass_cnt", a_pc, 0);
    chk("t6_data_e_out", a_deo, 0);
    model_reset;
    #3 rst_n = 1'b1;
    fill_a(1);
    cyc_a(1, 1, 0);
    cyc_a(1, 0, 0);
    chk("t6_restart_slot0", a_ch(10), 8);
    repeat (400) begin
      fill_rand;
      cyc_a($urandom_range(0, 15) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
